// File: rtl/debounce_bank.sv
// debounce_bank: NUM_CHANNELS independent debounce filters with rise/fall pulses and press toggle.
// Ports: i_Clk, i_Reset (sync, active-high), i_Bouncy -> o_Debounced, o_Rise, o_Fall, o_Toggle. Macro: DEBOUNCE_SYNC_EN.
module debounce_bank #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter bit RESET_LEVEL    = 1'b0
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [NUM_CHANNELS-1:0] i_Bouncy,
  output logic [NUM_CHANNELS-1:0] o_Debounced,
  output logic [NUM_CHANNELS-1:0] o_Rise,
  output logic [NUM_CHANNELS-1:0] o_Fall,
  output logic [NUM_CHANNELS-1:0] o_Toggle
);

  localparam int CW_RAW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LIM_M1 = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [NUM_CHANNELS-1:0] RST_VEC = {NUM_CHANNELS{RESET_LEVEL}};

  logic [NUM_CHANNELS-1:0] samp;

`ifdef DEBOUNCE_SYNC_EN
  logic [NUM_CHANNELS-1:0] meta_q;
  logic [NUM_CHANNELS-1:0] sync_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      meta_q <= RST_VEC;
      sync_q <= RST_VEC;
    end else begin
      meta_q <= i_Bouncy;
      sync_q <= meta_q;
    end
  end

  assign samp = sync_q;
`else
  assign samp = i_Bouncy;
`endif

  logic [CW-1:0]           cnt_q [NUM_CHANNELS];
  logic [CW-1:0]           cnt_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] deb_q, deb_d;
  logic [NUM_CHANNELS-1:0] rise_q, rise_d;
  logic [NUM_CHANNELS-1:0] fall_q, fall_d;
  logic [NUM_CHANNELS-1:0] tog_q, tog_d;

  // Any agreeing sample restarts the count; the
  // DEBOUNCE_LIMIT-th differing sample is accepted.
  always_comb begin
    deb_d  = deb_q;
    rise_d = '0;
    fall_d = '0;
    // Toggle follows the registered rise pulse,
    // so it flips one cycle after o_Rise.
    tog_d  = tog_q ^ rise_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (samp[i] != deb_q[i]) begin
        if (cnt_q[i] == LIM_M1) begin
          deb_d[i]  = samp[i];
          rise_d[i] = samp[i];
          fall_d[i] = ~samp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      deb_q  <= RST_VEC;
      rise_q <= '0;
      fall_q <= '0;
      tog_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      tog_q  <= tog_d;
    end
  end

  assign o_Debounced = deb_q;
  assign o_Rise      = rise_q;
  assign o_Fall      = fall_q;
  assign o_Toggle    = tog_q;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed checks of debounce_bank (LIMIT=4) and a LIMIT=1 instance.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] b;
  logic [3:0] deb, rise, fall, tog;
  logic [3:0] b1;
  logic [3:0] deb1, rise1, fall1, tog1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .NUM_CHANNELS(4),
    .DEBOUNCE_LIMIT(4),
    .RESET_LEVEL(1'b0)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Bouncy(b),
    .o_Debounced(deb),
    .o_Rise(rise),
    .o_Fall(fall),
    .o_Toggle(tog)
  );

  debounce_bank #(
    .NUM_CHANNELS(4),
    .DEBOUNCE_LIMIT(1),
    .RESET_LEVEL(1'b0)
  ) dut1 (
    .i_Clk(clk),
    .i_Reset(rst),
    .i_Bouncy(b1),
    .o_Debounced(deb1),
    .o_Rise(rise1),
    .o_Fall(fall1),
    .o_Toggle(tog1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    b   = v;
    b1  = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    b   = 4'b1111;
    b1  = 4'b0000;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({deb, rise, fall, tog} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got deb=%b rise=%b fall=%b tog=%b, want all 0",
               deb, rise, fall, tog);
    end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (deb !== 4'b0000 || rise !== 4'b0000) begin
        errors++;
        $display("FAIL reset_early edge%0d: got deb=%b rise=%b, want 0000 0000",
                 k, deb, rise);
      end
    end
    tick();
    checks++;
    if (deb !== 4'b1111 || rise !== 4'b1111 || tog !== 4'b0000) begin
      errors++;
      $display("FAIL reset_accept: got deb=%b rise=%b tog=%b, want 1111 1111 0000",
               deb, rise, tog);
    end
    tick();
    checks++;
    if (rise !== 4'b0000 || tog !== 4'b1111) begin
      errors++;
      $display("FAIL reset_pulse_end: got rise=%b tog=%b, want 0000 1111",
               rise, tog);
    end
  endtask

  task automatic test_glitch();
    logic [6:0] pat;
    do_reset(4'b0000);
    pat = 7'b1110111;
    for (int k = 6; k >= 0; k--) begin
      b[0] = pat[k];
      tick();
      checks++;
      if (deb[0] !== 1'b0 || rise[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch step%0d: got deb0=%b rise0=%b, want 0 0",
                 6 - k, deb[0], rise[0]);
      end
    end
    tick();
    checks++;
    if (deb[0] !== 1'b1 || rise[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_accept: got deb0=%b rise0=%b, want 1 1",
               deb[0], rise[0]);
    end
  endtask

  task automatic test_toggle();
    logic etog;
    int nr;
    int nf;
    do_reset(4'b0000);
    etog = 1'b0;
    nr = 0;
    nf = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 20; k++) begin
        b[1] = (k <= 10);
        tick();
        if (k == 5) etog = ~etog;
        if (rise[1]) nr++;
        if (fall[1]) nf++;
        checks++;
        if (rise[1] !== (k == 4) || fall[1] !== (k == 14) ||
            deb[1] !== (k >= 4 && k < 14) || tog[1] !== etog) begin
          errors++;
          $display("FAIL toggle p%0d k%0d: got r=%b f=%b d=%b t=%b, want r=%b f=%b d=%b t=%b",
                   p, k, rise[1], fall[1], deb[1], tog[1],
                   (k == 4), (k == 14), (k >= 4 && k < 14), etog);
        end
      end
    end
    checks++;
    if (nr != 3 || nf != 3) begin
      errors++;
      $display("FAIL toggle_counts: got rises=%0d falls=%0d, want 3 3", nr, nf);
    end
  endtask

  task automatic test_simultaneous();
    do_reset(4'b0000);
    b = 4'b1000;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (deb !== 4'b1000 || tog !== 4'b1000) begin
      errors++;
      $display("FAIL simul_setup: got deb=%b tog=%b, want 1000 1000", deb, tog);
    end
    b = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (rise !== 4'b0000 || fall !== 4'b0000 || deb !== 4'b1000) begin
        errors++;
        $display("FAIL simul_wait%0d: got deb=%b rise=%b fall=%b, want 1000 0000 0000",
                 k, deb, rise, fall);
      end
    end
    tick();
    checks++;
    if (deb !== 4'b0100 || rise !== 4'b0100 || fall !== 4'b1000) begin
      errors++;
      $display("FAIL simul_edge: got deb=%b rise=%b fall=%b, want 0100 0100 1000",
               deb, rise, fall);
    end
    tick();
    checks++;
    if (tog !== 4'b1100 || rise !== 4'b0000 || fall !== 4'b0000) begin
      errors++;
      $display("FAIL simul_after: got tog=%b rise=%b fall=%b, want 1100 0000 0000",
               tog, rise, fall);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset(4'b0000);
    b[0] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (deb[0] !== 1'b0 || rise[0] !== 1'b0) begin
        errors++;
        $display("FAIL midcount edge%0d: got deb0=%b rise0=%b, want 0 0",
                 k, deb[0], rise[0]);
      end
    end
    tick();
    checks++;
    if (deb[0] !== 1'b1 || rise[0] !== 1'b1) begin
      errors++;
      $display("FAIL midcount_accept: got deb0=%b rise0=%b, want 1 1",
               deb[0], rise[0]);
    end
    // reset in the pulse cycle clears pulse and blocks the toggle flip
    rst = 1'b1;
    tick();
    checks++;
    if (rise !== 4'b0000 || tog !== 4'b0000 || deb !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_pulse: got rise=%b tog=%b deb=%b, want 0000 0000 0000",
               rise, tog, deb);
    end
    rst = 1'b0;
  endtask

  task automatic test_limit1();
    logic [3:0] vin [5];
    logic [3:0] er  [5];
    logic [3:0] ef  [5];
    logic [3:0] et  [5];
    vin = '{4'b1010, 4'b0101, 4'b0101, 4'b1111, 4'b0000};
    er  = '{4'b1010, 4'b0101, 4'b0000, 4'b1010, 4'b0000};
    ef  = '{4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1111};
    et  = '{4'b0000, 4'b1010, 4'b1111, 4'b1111, 4'b0101};
    do_reset(4'b0000);
    for (int k = 0; k < 5; k++) begin
      b1 = vin[k];
      tick();
      checks++;
      if (deb1 !== vin[k] || rise1 !== er[k] ||
          fall1 !== ef[k] || tog1 !== et[k]) begin
        errors++;
        $display("FAIL limit1 step%0d: got d=%b r=%b f=%b t=%b, want d=%b r=%b f=%b t=%b",
                 k, deb1, rise1, fall1, tog1, vin[k], er[k], ef[k], et[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    b   = 4'b0000;
    b1  = 4'b0000;
    #1;
    test_reset();
    test_glitch();
    test_toggle();
    test_simultaneous();
    test_reset_midcount();
    test_limit1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Parametrised, multi-channel successor to the single-switch debounce filter plus LED toggle pair.
- Filters NUM_CHANNELS bouncy inputs (buttons, switches) independently.
- Per channel, provides a stable level, one-cycle rise and fall pulses, and a press-toggled level.
- Sits between board pin inputs and user logic. Replaces one filter instance plus separate toggle logic per switch.

Parameters:
- NUM_CHANNELS, 4, number of independent input channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive clock cycles an input must differ from the stable level before the stable level changes (>=1).
- RESET_LEVEL, 0, stable level loaded into every channel at reset (0 or 1).

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Bouncy  input  NUM_CHANNELS  raw switch inputs, one bit per channel.
- o_Debounced  output  NUM_CHANNELS  filtered stable level per channel.
- o_Rise  output  NUM_CHANNELS  one-cycle pulse when o_Debounced goes 0->1.
- o_Fall  output  NUM_CHANNELS  one-cycle pulse when o_Debounced goes 1->0.
- o_Toggle  output  NUM_CHANNELS  level that inverts on each o_Rise of its channel.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high, sampled on the i_Clk rising edge.
- Reset values, all channels:
  - counter = 0.
  - o_Debounced = RESET_LEVEL.
  - o_Rise = 0, o_Fall = 0.
  - o_Toggle = 0.
- Counter width: $clog2(DEBOUNCE_LIMIT+1), minimum 1. The counter never exceeds DEBOUNCE_LIMIT-1.
- Per channel, each cycle, with s = sampled input bit (raw i_Bouncy bit, or its synchroniser output when enabled):
  - s == o_Debounced: counter <= 0.
  - s != o_Debounced and counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
  - s != o_Debounced and counter == DEBOUNCE_LIMIT-1: o_Debounced <= s, counter <= 0.
- Net effect: a change is accepted only after DEBOUNCE_LIMIT consecutive differing samples. Any agreeing sample restarts the count (glitch rejection).
- Latency: if i_Bouncy changes just before edge 1 and stays stable, o_Debounced changes after edge DEBOUNCE_LIMIT. Add 2 cycles when DEBOUNCE_SYNC_EN is defined.
- DEBOUNCE_LIMIT == 1: o_Debounced is a one-cycle-registered copy of s.
- o_Rise and o_Fall are registered in the same cycle o_Debounced updates:
  - each is high for exactly one cycle per accepted transition;
  - never both high on one channel;
  - back-to-back pulses require at least DEBOUNCE_LIMIT cycles between them.
- o_Toggle flips in the cycle after o_Rise is high, i.e. one cycle after the accepted rising edge.
- o_Fall never affects o_Toggle.
- Channels are fully independent. Simultaneous events on several channels are all handled in the same cycle.
- Reset mid-count discards partial counts. Reset asserted in a pulse cycle forces the pulses low on the next edge.
- After reset release, an input already different from RESET_LEVEL produces a transition (and pulse) after DEBOUNCE_LIMIT cycles. This is intended power-on behaviour.
- No combinational path from inputs to outputs; all outputs come straight from registers.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: each i_Bouncy bit passes through a 2-flop synchroniser before the filter.
  - Synchroniser flops reset to RESET_LEVEL.
  - Adds exactly 2 cycles of latency to every transition.
- Not defined: i_Bouncy is sampled directly. The input must already be synchronous, or metastability is the integrator's responsibility.

Test Plan (NUM_CHANNELS=4, DEBOUNCE_LIMIT=4, RESET_LEVEL=0, macro undefined unless stated):
- Reset: i_Reset=1 for 2 cycles with i_Bouncy=4'b1111 -> o_Debounced=0, o_Rise=0, o_Fall=0, o_Toggle=0 during reset. After release, o_Debounced=4'b1111 exactly 4 edges later, with o_Rise=4'b1111 for 1 cycle.
- Glitch rejection: ch0 driven 1 for 3 cycles, then 0 for 1, then 1 for 3 -> o_Debounced[0] stays 0, no o_Rise[0]. Holding 1 for a 4th cycle -> o_Debounced[0]=1 and o_Rise[0]=1 on that edge.
- Toggle: ch1 three clean presses (1 for 10 cycles, 0 for 10 cycles each) -> o_Rise[1] 3 pulses, o_Fall[1] 3 pulses, o_Toggle[1] sequence 0->1->0->1, each flip one cycle after o_Rise[1].
- Independence and simultaneity: ch2 rises and ch3 falls (after being stable high) on the same cycle -> o_Rise[2] and o_Fall[3] pulse in the same cycle; ch0 and ch1 unchanged.
- Reset mid-count: ch0 differing for 3 cycles, i_Reset pulsed 1 cycle, input held -> transition occurs 4 edges after reset release, not earlier.
- DEBOUNCE_SYNC_EN defined: a clean 0->1 step on ch0 -> o_Debounced[0] rises 6 edges after the step. LIMIT=1 build with macro undefined -> follows input with 1-cycle latency.
